// File: rtl/pipe_sequencer_if.sv
// Bus bundle between the pipeline sequencer and its surroundings: run control,
// writeback gating, register-file access and the debug port.
interface pipe_sequencer_if #(
    parameter int AW    = 3,
    parameter int DW    = 8,
    parameter int CNT_W = 16
);
    logic             run_req;
    logic             halt_req;
    logic             step_req;
    logic             pc_en;
    logic             issue_valid;
    logic             wb_valid;
    logic             pipe_we;
    logic [AW-1:0]    pipe_waddr;
    logic [DW-1:0]    pipe_wdata;
    logic [AW-1:0]    pipe_raddr;
    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [DW-1:0]    rf_wdata;
    logic [AW-1:0]    rf_raddr;
    logic [DW-1:0]    rf_rdata;
    logic             dbg_req;
    logic             dbg_we;
    logic [AW-1:0]    dbg_addr;
    logic [DW-1:0]    dbg_wdata;
    logic             dbg_ack;
    logic [DW-1:0]    dbg_rdata;
    logic             halted;
    logic [CNT_W-1:0] retired_cnt;

    modport master (
        input  run_req, halt_req, step_req,
        input  pipe_we, pipe_waddr, pipe_wdata, pipe_raddr, rf_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output pc_en, issue_valid, wb_valid,
        output rf_we, rf_waddr, rf_wdata, rf_raddr,
        output dbg_ack, dbg_rdata, halted, retired_cnt
    );

    modport slave (
        output run_req, halt_req, step_req,
        output pipe_we, pipe_waddr, pipe_wdata, pipe_raddr, rf_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  pc_en, issue_valid, wb_valid,
        input  rf_we, rf_waddr, rf_wdata, rf_raddr,
        input  dbg_ack, dbg_rdata, halted, retired_cnt
    );
endinterface

// File: rtl/pipe_sequencer.sv
// Run/halt/single-step controller: gates issue, tracks valid tokens to writeback,
// drains before halting and hands the register file to the debug port while halted.
module pipe_sequencer #(
    parameter int DEPTH    = 3,
    parameter int AW       = 3,
    parameter int DW       = 8,
    parameter int CNT_W    = 16,
    parameter bit BOOT_RUN = 1'b1
) (
    input logic              clk,
    input logic              reset,
    pipe_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        S_RUN,
        S_STEP,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t           r_state;
    logic             r_issue;
    logic             r_halted;
    logic [DEPTH-1:0] r_vpipe;
    logic [CNT_W-1:0] r_retired;
    logic             r_dbgAck;
    logic [DW-1:0]    r_dbgRdata;

    logic [DEPTH-1:0] w_vpipeNext;
    logic             w_wbValid;
    logic             w_grant;
    logic             w_rfWe;
    logic [AW-1:0]    w_rfWaddr;
    logic [DW-1:0]    w_rfWdata;
    logic [AW-1:0]    w_rfRaddr;

    assign w_vpipeNext = {r_vpipe[DEPTH-2:0], r_issue};
    assign w_wbValid   = r_vpipe[DEPTH-1];
    assign w_grant     = r_halted && bus.dbg_req && !r_dbgAck;

    // Halting waits until the shifted-in token vector is empty, so the last
    // real instruction has already been seen at writeback.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= BOOT_RUN ? S_RUN : S_HALTED;
            r_issue  <= BOOT_RUN;
            r_halted <= !BOOT_RUN;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (bus.halt_req) begin
                        r_state <= S_DRAIN;
                        r_issue <= 1'b0;
                    end
                end
                S_STEP: begin
                    r_state <= S_DRAIN;
                    r_issue <= 1'b0;
                end
                S_DRAIN: begin
                    if (w_vpipeNext == '0) begin
                        r_state  <= S_HALTED;
                        r_halted <= 1'b1;
                    end
                end
                S_HALTED: begin
                    if (bus.step_req) begin
                        r_state  <= S_STEP;
                        r_issue  <= 1'b1;
                        r_halted <= 1'b0;
                    end else if (bus.run_req) begin
                        r_state  <= S_RUN;
                        r_issue  <= 1'b1;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_HALTED;
                    r_issue  <= 1'b0;
                    r_halted <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vpipe    <= '0;
            r_retired  <= '0;
            r_dbgAck   <= 1'b0;
            r_dbgRdata <= '0;
        end else begin
            r_vpipe  <= w_vpipeNext;
            r_dbgAck <= w_grant;
            if (w_grant) begin
                r_dbgRdata <= bus.rf_rdata;
            end
            if (w_wbValid && (r_retired != '1)) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    // The debug port owns the register file only in its grant cycle.
    always_comb begin
        w_rfWe    = bus.pipe_we & w_wbValid;
        w_rfWaddr = bus.pipe_waddr;
        w_rfWdata = bus.pipe_wdata;
        w_rfRaddr = bus.pipe_raddr;
        if (w_grant) begin
            w_rfWe    = bus.dbg_we;
            w_rfWaddr = bus.dbg_addr;
            w_rfWdata = bus.dbg_wdata;
            w_rfRaddr = bus.dbg_addr;
        end
    end

    assign bus.pc_en       = r_issue;
    assign bus.issue_valid = r_issue;
    assign bus.wb_valid    = w_wbValid;
    assign bus.halted      = r_halted;
    assign bus.rf_we       = w_rfWe;
    assign bus.rf_waddr    = w_rfWaddr;
    assign bus.rf_wdata    = w_rfWdata;
    assign bus.rf_raddr    = w_rfRaddr;
    assign bus.dbg_ack     = r_dbgAck;
    assign bus.dbg_rdata   = r_dbgRdata;
    assign bus.retired_cnt = r_retired;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer: boot run, drain/halt, single step, debug
// access, request priority, counter saturation and asynchronous reset.
module tb_pipe_sequencer;

    logic clk;
    logic reset;
    int   vecCount;
    int   missCount;
    int   cyc;

    pipe_sequencer_if #(.AW(3), .DW(8), .CNT_W(16)) bus ();
    pipe_sequencer_if #(.AW(3), .DW(8), .CNT_W(4))  sat ();

    pipe_sequencer #(
        .DEPTH(3), .AW(3), .DW(8), .CNT_W(16), .BOOT_RUN(1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    pipe_sequencer #(
        .DEPTH(3), .AW(3), .DW(8), .CNT_W(4), .BOOT_RUN(1'b1)
    ) dutSat (
        .clk   (clk),
        .reset (reset),
        .bus   (sat.master)
    );

    // Register file model behind the main instance
    logic [7:0] rfMem [8];

    always @(posedge clk) begin
        if (bus.rf_we) rfMem[bus.rf_waddr] <= bus.rf_wdata;
    end
    assign bus.rf_rdata = rfMem[bus.rf_raddr];

    assign sat.run_req    = 1'b0;
    assign sat.halt_req   = 1'b0;
    assign sat.step_req   = 1'b0;
    assign sat.pipe_we    = 1'b0;
    assign sat.pipe_waddr = '0;
    assign sat.pipe_wdata = '0;
    assign sat.pipe_raddr = '0;
    assign sat.rf_rdata   = '0;
    assign sat.dbg_req    = 1'b0;
    assign sat.dbg_we     = 1'b0;
    assign sat.dbg_addr   = '0;
    assign sat.dbg_wdata  = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic run, input logic halt, input logic step);
        bus.run_req  = run;
        bus.halt_req = halt;
        bus.step_req = step;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        vecCount       = 0;
        missCount      = 0;
        cyc            = 0;
        reset          = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        bus.pipe_we    = 1'b0;
        bus.pipe_waddr = '0;
        bus.pipe_wdata = 8'h11;
        bus.pipe_raddr = 3'd1;
        bus.dbg_req    = 1'b0;
        bus.dbg_we     = 1'b0;
        bus.dbg_addr   = '0;
        bus.dbg_wdata  = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_retired", 32'(bus.retired_cnt), 0);
        checkOutput("rst_wb_valid", 32'(bus.wb_valid), 0);
        checkOutput("rst_dbg_ack", 32'(bus.dbg_ack), 0);
        checkOutput("rst_dbg_rdata", 32'(bus.dbg_rdata), 0);
        checkOutput("rst_halted", 32'(bus.halted), 0);
        checkOutput("rst_pc_en", 32'(bus.pc_en), 1);

        // Boot straight into RUN; writeback is gated until tokens arrive
        reset       = 1'b1;
        cyc         = 0;
        bus.pipe_we = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.pipe_waddr = 3'(c);
            #1;
            checkOutput("boot_pc_en", 32'(bus.pc_en), 1);
            checkOutput("boot_wb_valid", 32'(bus.wb_valid), 32'(c >= 3));
            checkOutput("boot_rf_we", 32'(bus.rf_we), 32'(c >= 3));
            stepCycle();
        end
        checkOutput("boot_retired", 32'(bus.retired_cnt), 7);
        checkOutput("sat_retired_mid", 32'(sat.retired_cnt), 7);

        while (cyc < 20) stepCycle();
        checkOutput("sat_retired_hold", 32'(sat.retired_cnt), 15);

        // Halt request drains three in-flight instructions; late run/step dropped
        applyStimulus(1'b0, 1'b1, 1'b0);
        stepCycle();
        for (int c = 21; c < 28; c++) begin
            if (c == 22) applyStimulus(1'b1, 1'b0, 1'b1);
            else         applyStimulus(1'b0, 1'b0, 1'b0);
            #1;
            checkOutput("drain_pc_en", 32'(bus.pc_en), 0);
            checkOutput("drain_wb_valid", 32'(bus.wb_valid), 32'(c <= 23));
            checkOutput("drain_halted", 32'(bus.halted), 32'(c >= 24));
            checkOutput("drain_retired", 32'(bus.retired_cnt), 32'(((c < 24) ? c : 24) - 3));
            stepCycle();
        end
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Single step
        applyStimulus(1'b0, 1'b0, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            #1;
            checkOutput("step_pc_en", 32'(bus.pc_en), 32'(k == 1));
            checkOutput("step_wb_valid", 32'(bus.wb_valid), 32'(k == 4));
            checkOutput("step_rf_we", 32'(bus.rf_we), 32'(k == 4));
            checkOutput("step_halted", 32'(bus.halted), 32'(k >= 5));
            stepCycle();
        end
        checkOutput("step_retired", 32'(bus.retired_cnt), 22);

        // Debug write then back-to-back reads while halted
        bus.dbg_req   = 1'b1;
        bus.dbg_we    = 1'b1;
        bus.dbg_addr  = 3'd5;
        bus.dbg_wdata = 8'hA7;
        #1;
        checkOutput("dbgw_rf_we", 32'(bus.rf_we), 1);
        checkOutput("dbgw_rf_waddr", 32'(bus.rf_waddr), 5);
        checkOutput("dbgw_rf_wdata", 32'(bus.rf_wdata), 32'h A7);
        checkOutput("dbgw_ack_pre", 32'(bus.dbg_ack), 0);
        stepCycle();
        checkOutput("dbgw_ack", 32'(bus.dbg_ack), 1);
        checkOutput("dbgw_rf_we_ack", 32'(bus.rf_we), 0);
        bus.dbg_req = 1'b0;
        stepCycle();
        checkOutput("dbgw_ack_post", 32'(bus.dbg_ack), 0);
        checkOutput("idle_rf_raddr", 32'(bus.rf_raddr), 1);

        bus.dbg_req = 1'b1;
        bus.dbg_we  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("dbgr_ack", 32'(bus.dbg_ack), 32'(k % 2));
            checkOutput("dbgr_rf_raddr", 32'(bus.rf_raddr), (k % 2 == 0) ? 5 : 1);
            checkOutput("dbgr_rf_we", 32'(bus.rf_we), 0);
            if (k == 1) checkOutput("dbgr_rdata", 32'(bus.dbg_rdata), 32'h A7);
            stepCycle();
        end
        bus.dbg_req = 1'b0;
        stepCycle();

        // Debug request raised in RUN waits for HALTED
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        bus.pipe_we   = 1'b0;
        bus.dbg_req   = 1'b1;
        bus.dbg_we    = 1'b1;
        bus.dbg_addr  = 3'd2;
        bus.dbg_wdata = 8'h3C;
        for (int k = 0; k < 2; k++) begin
            #1;
            checkOutput("dbgrun_rf_we", 32'(bus.rf_we), 0);
            checkOutput("dbgrun_ack", 32'(bus.dbg_ack), 0);
            stepCycle();
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            #1;
            checkOutput("dbgwait_halted", 32'(bus.halted), 32'(k == 4));
            checkOutput("dbgwait_rf_we", 32'(bus.rf_we), 32'(k == 4));
            checkOutput("dbgwait_ack", 32'(bus.dbg_ack), 0);
            if (k == 4) checkOutput("dbgwait_waddr", 32'(bus.rf_waddr), 2);
            if (k < 4) stepCycle();
        end
        stepCycle();
        checkOutput("dbgwait_ack_after", 32'(bus.dbg_ack), 1);
        bus.dbg_req = 1'b0;
        stepCycle();

        // Step wins over run when both arrive together
        applyStimulus(1'b1, 1'b0, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            #1;
            checkOutput("prio_pc_en", 32'(bus.pc_en), 32'(k == 1));
            checkOutput("prio_halted", 32'(bus.halted), 32'(k >= 5));
            stepCycle();
        end

        // Asynchronous reset in the middle of a drain
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (4) stepCycle();
        applyStimulus(1'b0, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("middrain_wb_valid", 32'(bus.wb_valid), 1);
        checkOutput("middrain_halted", 32'(bus.halted), 0);
        reset = 1'b0;
        #1;
        checkOutput("arst_wb_valid", 32'(bus.wb_valid), 0);
        checkOutput("arst_dbg_ack", 32'(bus.dbg_ack), 0);
        checkOutput("arst_retired", 32'(bus.retired_cnt), 0);
        checkOutput("arst_pc_en", 32'(bus.pc_en), 1);
        stepCycle();
        reset       = 1'b1;
        cyc         = 0;
        bus.pipe_we = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput("rerun_wb_valid", 32'(bus.wb_valid), 32'(c >= 3));
            checkOutput("rerun_rf_we", 32'(bus.rf_we), 32'(c >= 3));
            stepCycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
